pe_issue_ctrl: RTL and testbench

PE_ISSUE_CTRL -- requirements
Module: pe_issue_ctrl

---
 rtl/pe_issue_if.sv | 29 ++
 rtl/pe_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_pe_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_issue_if.sv
// rtl/pe_issue_if.sv - control, instruction, memory, PE and result-buffer signals of pe_issue_ctrl
interface pe_issue_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [7:0]        inst_addr;
    logic [7:0]        inst_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              pe_vld;
    logic [1:0]        pe_ctl;
    logic [31:0]       pe_result;
    logic              pe_vld_o;
    logic              res_we;
    logic [7:0]        res_addr;
    logic [31:0]       res_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, inst_data, pe_result, pe_vld_o,
        output inst_addr, mem_addr, pe_vld, pe_ctl, res_we, res_addr, res_data, busy, done, err
    );

    modport slave (
        output start, inst_data, pe_result, pe_vld_o,
        input  inst_addr, mem_addr, pe_vld, pe_ctl, res_we, res_addr, res_data, busy, done, err
    );
endinterface

// File: rtl/pe_issue_ctrl.sv
// rtl/pe_issue_ctrl.sv - instruction-driven beat issuer and result collector for one PE
module pe_issue_ctrl #(
    parameter int NUM_INST = 4,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    pe_issue_if.master bus
);
    localparam int              TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]      LAST_INST   = 8'(NUM_INST - 1);
    localparam logic [TW-1:0]   DRAIN_LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, FIN} state_t;
    state_t state, state_nxt;

    logic [7:0]        inst_idx, count, iter, res_idx, res_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [8:0]        exp_cnt, rcv_cnt;
    logic [TW-1:0]     drain_cnt;
    logic [31:0]       res_data;
    logic              res_we, err;
    logic              pe_vld, busy, done;
    logic [1:0]        pe_ctl;
    logic              last_inst, last_beat, drain_done, drain_timeout, res_open, res_accept;

    assign last_inst     = (inst_idx == LAST_INST);
    assign last_beat     = (iter == count - 8'd1);
    assign drain_done    = (rcv_cnt == exp_cnt);
    assign drain_timeout = (drain_cnt == DRAIN_LIMIT);
    assign res_open      = (state == LOAD) || (state == ISSUE) || (state == DRAIN);
    // Results beyond the expected count are treated as protocol errors, never written
    assign res_accept    = bus.pe_vld_o && res_open && (rcv_cnt < exp_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pe_vld    = 1'b0;
        pe_ctl    = 2'b00;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (bus.start) state_nxt = LOAD;
            LOAD: begin
                if (bus.inst_data != 8'd0) state_nxt = ISSUE;
                else if (last_inst)        state_nxt = DRAIN;
            end
            ISSUE: begin
                pe_vld = 1'b1;
                pe_ctl = {last_beat, iter == 8'd0};
                if (last_beat) state_nxt = last_inst ? DRAIN : LOAD;
            end
            DRAIN: if (drain_done || drain_timeout) state_nxt = FIN;
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_idx  <= '0;
            count     <= '0;
            iter      <= '0;
            res_idx   <= '0;
            res_addr  <= '0;
            mem_addr  <= '0;
            exp_cnt   <= '0;
            rcv_cnt   <= '0;
            drain_cnt <= '0;
            res_data  <= '0;
            res_we    <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_we    <= res_accept;
            drain_cnt <= '0;
            if (res_accept) begin
                res_data <= bus.pe_result;
                res_addr <= res_idx;
                res_idx  <= res_idx + 8'd1;
                rcv_cnt  <= rcv_cnt + 9'd1;
            end else if (bus.pe_vld_o) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: if (bus.start) begin
                    inst_idx <= '0;
                    mem_addr <= '0;
                    res_idx  <= '0;
                    res_addr <= '0;
                    exp_cnt  <= '0;
                    rcv_cnt  <= '0;
                    err      <= 1'b0;
                end
                LOAD: begin
                    count <= bus.inst_data;
                    iter  <= '0;
                    if (bus.inst_data != 8'd0) exp_cnt  <= exp_cnt + 9'd1;
                    else if (!last_inst)       inst_idx <= inst_idx + 8'd1;
                end
                ISSUE: begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                    iter     <= iter + 8'd1;
                    if (last_beat && !last_inst) inst_idx <= inst_idx + 8'd1;
                end
                DRAIN: if (!drain_done) begin
                    drain_cnt <= drain_cnt + TW'(1);
                    if (drain_timeout) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.inst_addr = inst_idx;
    assign bus.mem_addr  = mem_addr;
    assign bus.pe_vld    = pe_vld;
    assign bus.pe_ctl    = pe_ctl;
    assign bus.res_we    = res_we;
    assign bus.res_addr  = res_addr;
    assign bus.res_data  = res_data;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err;
endmodule

// File: tb/tb_pe_issue_ctrl.sv
// tb/tb_pe_issue_ctrl.sv - directed table-driven bench for pe_issue_ctrl
module tb_pe_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pe_issue_if #(.ADDR_W(16)) bus ();

    pe_issue_ctrl #(.NUM_INST(4), .ADDR_W(16), .TIMEOUT(255)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0][7:0] cnt;
        bit              pe_on;
        int              beats;
        int              span;
        int              writes;
        int              mem_end;
        bit              err;
    } vec_t;
    typedef struct { logic [15:0] addr; logic [1:0] ctl; } beat_t;
    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    logic [7:0] imem [256];
    bit pe_on = 0, mon_on = 0;
    logic pe_model_vld = 1'b0, inj_vld = 1'b0;
    logic [31:0] pe_model_res = '0, inj_data = '0, acc = '0, res_pend = '0;
    bit pend = 0;

    beat_t exp_beat_q[$];
    wr_t   exp_wr_q[$];
    int beats_seen, writes_seen, done_cnt, first_cyc, last_cyc, start_cyc;

    assign bus.inst_data = imem[bus.inst_addr];
    assign bus.pe_vld_o  = pe_model_vld | inj_vld;
    assign bus.pe_result = inj_vld ? inj_data : pe_model_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // PE model: accumulates addresses, returns the sum one cycle after the last beat
    always @(negedge clk) begin
        pe_model_vld = 1'b0;
        if (pend) begin
            pe_model_vld = 1'b1;
            pe_model_res = res_pend;
            pend = 0;
        end
        if (pe_on && rst_n && bus.pe_vld) begin
            acc = bus.pe_ctl[0] ? 32'(bus.mem_addr) : acc + 32'(bus.mem_addr);
            if (bus.pe_ctl[1]) begin
                res_pend = acc;
                pend = 1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        beat_t b;
        wr_t   w;
        if (mon_on && rst_n) begin
            if (bus.pe_vld) begin
                if (beats_seen == 0) begin
                    first_cyc = cyc;
                    check("first_beat_latency", longint'(cyc - start_cyc), 2);
                end
                last_cyc = cyc;
                beats_seen++;
                if (exp_beat_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    b = exp_beat_q.pop_front();
                    check("beat_mem_addr", longint'(bus.mem_addr), longint'(b.addr));
                    check("beat_pe_ctl", longint'(bus.pe_ctl), longint'(b.ctl));
                end
            end else begin
                check("ctl_without_vld", longint'(bus.pe_ctl), 0);
            end
            if (bus.res_we) begin
                writes_seen++;
                if (exp_wr_q.size() == 0) check("extra_write", 1, 0);
                else begin
                    w = exp_wr_q.pop_front();
                    check("res_addr", longint'(bus.res_addr), longint'(w.addr));
                    check("res_data", longint'(bus.res_data), longint'(w.data));
                end
            end
            if (bus.done) done_cnt++;
        end
    end

    function automatic vec_t mk(input int c0, c1, c2, c3, beats, span, writes, mem_end);
        vec_t v;
        v.cnt[0] = 8'(c0); v.cnt[1] = 8'(c1); v.cnt[2] = 8'(c2); v.cnt[3] = 8'(c3);
        v.pe_on = 1; v.beats = beats; v.span = span; v.writes = writes;
        v.mem_end = mem_end; v.err = 0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int base = 0, widx = 0, t;
        exp_beat_q.delete();
        exp_wr_q.delete();
        for (int i = 0; i < 4; i++) begin
            int c;
            c = int'(v.cnt[i]);
            imem[i] = v.cnt[i];
            for (int k = 0; k < c; k++) begin
                beat_t b;
                b.addr = 16'(base + k);
                b.ctl  = {k == c - 1, k == 0};
                exp_beat_q.push_back(b);
            end
            if (c != 0) begin
                wr_t w;
                w.addr = 8'(widx);
                w.data = 32'(c * base + c * (c - 1) / 2);
                exp_wr_q.push_back(w);
                widx++;
            end
            base += c;
        end
        pe_on = v.pe_on;
        beats_seen = 0; writes_seen = 0; done_cnt = 0; first_cyc = 0; last_cyc = 0;
        mon_on = 1;
        @(negedge clk);
        bus.start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        for (t = 0; t < 2000; t++) begin
            if (done_cnt > 0) break;
            @(negedge clk);
        end
        if (t >= 2000) $display("FAIL vec%0d_done_timeout: got 0 done pulses expected 1", idx);
        repeat (3) @(negedge clk);
        mon_on = 0;
        check($sformatf("vec%0d_done_count", idx), done_cnt, 1);
        check($sformatf("vec%0d_beats", idx), beats_seen, v.beats);
        check($sformatf("vec%0d_writes", idx), writes_seen, v.writes);
        check($sformatf("vec%0d_mem_end", idx), longint'(bus.mem_addr), v.mem_end);
        check($sformatf("vec%0d_err", idx), longint'(bus.err), longint'(v.err));
        check($sformatf("vec%0d_busy_after", idx), longint'(bus.busy), 0);
        check($sformatf("vec%0d_beats_left", idx), exp_beat_q.size(), 0);
        check($sformatf("vec%0d_writes_left", idx), exp_wr_q.size(), 0);
        if (v.beats > 0) check($sformatf("vec%0d_span", idx), longint'(last_cyc - first_cyc + 1), v.span);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst_addr"}, longint'(bus.inst_addr), 0);
        check({tag, "_mem_addr"}, longint'(bus.mem_addr), 0);
        check({tag, "_pe_vld"}, longint'(bus.pe_vld), 0);
        check({tag, "_pe_ctl"}, longint'(bus.pe_ctl), 0);
        check({tag, "_res_we"}, longint'(bus.res_we), 0);
        check({tag, "_res_addr"}, longint'(bus.res_addr), 0);
        check({tag, "_res_data"}, longint'(bus.res_data), 0);
        check({tag, "_busy"}, longint'(bus.busy), 0);
        check({tag, "_done"}, longint'(bus.done), 0);
        check({tag, "_err"}, longint'(bus.err), 0);
    endtask

    initial begin
        vec_t vecs[5];
        int t, lb;
        bit any_we;
        vecs[0] = mk(3, 2, 1, 4, 10, 13, 4, 10);
        vecs[1] = mk(1, 1, 1, 1, 4, 7, 4, 4);
        vecs[2] = mk(2, 0, 0, 2, 4, 7, 2, 4);
        vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(5, 0, 3, 0, 8, 10, 2, 8);
        for (int i = 0; i < 256; i++) imem[i] = 8'd0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Stray result in IDLE: flags err, never written; next start clears it
        any_we = 0;
        inj_data = 32'hDEAD_BEEF;
        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            any_we |= bus.res_we;
            @(negedge clk);
        end
        check("idle_pulse_err", longint'(bus.err), 1);
        check("idle_pulse_no_write", longint'(any_we), 0);
        imem[0] = 8'd1; imem[1] = 8'd0; imem[2] = 8'd0; imem[3] = 8'd0;
        pe_on = 1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_clears_err", longint'(bus.err), 0);
        check("start_busy", longint'(bus.busy), 1);
        for (t = 0; t < 100; t++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        check("clear_run_done", longint'(t < 100), 1);
        check("clear_run_err", longint'(bus.err), 0);
        @(negedge clk);

        // PE silent: done and err follow DRAIN entry by TIMEOUT cycles
        imem[0] = 8'd0; imem[1] = 8'd0; imem[2] = 8'd0; imem[3] = 8'd3;
        pe_on = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (t = 0; t < 50; t++) begin
            if (bus.pe_vld && bus.pe_ctl[1]) break;
            @(negedge clk);
        end
        check("timeout_last_beat_seen", longint'(t < 50), 1);
        lb = cyc;
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        check("timeout_done_delay", longint'(cyc - lb), 256);
        check("timeout_err_at_done", longint'(bus.err), 1);
        repeat (3) @(negedge clk);
        check("timeout_err_sticky", longint'(bus.err), 1);
        check("timeout_idle", longint'(bus.busy), 0);

        // Reset during ISSUE of instruction 2 aborts the run immediately
        imem[0] = 8'd3; imem[1] = 8'd2; imem[2] = 8'd1; imem[3] = 8'd4;
        pe_on = 1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (t = 0; t < 50; t++) begin
            if (bus.pe_vld && bus.inst_addr == 8'd2) break;
            @(negedge clk);
        end
        check("midrun_reached_inst2", longint'(t < 50), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        any_we = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any_we |= bus.res_we;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any_we |= bus.res_we;
        end
        check("midrun_no_write", longint'(any_we), 0);
        check("midrun_err_after_release", longint'(bus.err), 0);
        run_vec(vecs[0], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
